uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/tinyqv_peri_pkg.sv | 13 +
 rtl/sync_fifo.sv | 75 +++++++
 rtl/uart_rx_fifo.sv | 85 ++++++++
 tb/tb_uart_rx_fifo.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/tinyqv_peri_pkg.sv
// ============================================================================
// tinyqv_peri_pkg : shared peripheral constants for the TinyQV UART block
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package tinyqv_peri_pkg;
  localparam logic [3:0] PERI_UART          = 4'h4;
  localparam logic [3:0] PERI_UART_STATUS   = 4'h5;
  localparam int         UART_RX_FIFO_DEPTH = 4;
endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// sync_fifo : byte storage with wrapping pointers and a separately tracked level
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int LW    = PW + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_clear,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata,
  output logic [LW-1:0] o_level,
  output logic [LW-1:0] o_level_next,
  output logic          o_push_taken
);

  localparam logic [LW-1:0] c_depth = LW'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic          w_push;
  logic          w_pop;

  // Eligibility uses the pre-pop level, so a full FIFO refuses a push even
  // when a pop lands on the same edge.
  assign w_push = i_push && (r_level != c_depth) && !i_clear;
  assign w_pop  = i_pop  && (r_level != '0)      && !i_clear;

  always_comb begin
    o_level_next = r_level;
    if (i_clear)
      o_level_next = '0;
    else if (w_push && !w_pop)
      o_level_next = r_level + LW'(1);
    else if (w_pop && !w_push)
      o_level_next = r_level - LW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      r_level <= o_level_next;
      if (i_clear) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + PW'(1);
        if (w_pop)  r_rptr <= r_rptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata      = (r_level != '0) ? r_mem[r_rptr] : 8'h00;
  assign o_level      = r_level;
  assign o_push_taken = w_push;

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// uart_rx_fifo : receive FIFO between uart_rx and the CPU read port
//   Optional flow control enabled by macro UART_RX_FIFO_RTS_EN.
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo
  import tinyqv_peri_pkg::*;
#(
  parameter  int DEPTH     = UART_RX_FIFO_DEPTH,
  parameter  int RTS_LEVEL = DEPTH - 1,
  localparam int LW        = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_read,
  input  logic          rd_req,
  input  logic          clear,
  output logic [7:0]    rd_data,
  output logic          not_empty,
  output logic [LW-1:0] level,
  output logic          rts
);

  logic          r_rst_done;
  logic          r_in_read;
  logic          r_not_empty;
  logic          w_push_req;
  logic          w_push_taken;
  logic [LW-1:0] w_level_next;

  // The acknowledge pulse masks the still-high in_valid so one byte is taken once.
  assign w_push_req = in_valid && !r_in_read && r_rst_done;

  sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rstn         (rstn),
    .i_push       (w_push_req),
    .i_pop        (rd_req),
    .i_clear      (clear),
    .i_wdata      (in_data),
    .o_rdata      (rd_data),
    .o_level      (level),
    .o_level_next (w_level_next),
    .o_push_taken (w_push_taken)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rst_done  <= 1'b0;
      r_in_read   <= 1'b0;
      r_not_empty <= 1'b0;
    end else begin
      r_rst_done  <= 1'b1;
      r_in_read   <= w_push_taken;
      r_not_empty <= (w_level_next != '0);
    end
  end

  assign in_read   = r_in_read;
  assign not_empty = r_not_empty;

`ifdef UART_RX_FIFO_RTS_EN
  localparam logic [LW-1:0] c_rts_level = LW'(RTS_LEVEL);

  logic r_rts;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_rts <= 1'b0;
    else       r_rts <= (w_level_next >= c_rts_level);
  end

  assign rts = r_rts;
`else
  assign rts = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// tb_uart_rx_fifo : vector table plus data scoreboard for uart_rx_fifo (DEPTH=4)
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_fifo;

  localparam int DEPTH     = 4;
  localparam int LW        = $clog2(DEPTH) + 1;
  localparam int RTS_LEVEL = DEPTH - 1;

  typedef struct {
    logic          v;
    logic [7:0]    d;
    logic          rd;
    logic          clr;
    logic [LW-1:0] e_level;
    logic          e_inread;
  } vec_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_read;
  logic          rd_req;
  logic          clear;
  logic [7:0]    rd_data;
  logic          not_empty;
  logic [LW-1:0] level;
  logic          rts;

  int         n_chk  = 0;
  int         n_fail = 0;
  vec_t       vecs[$];
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DEPTH     (DEPTH),
    .RTS_LEVEL (RTS_LEVEL)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_read   (in_read),
    .rd_req    (rd_req),
    .clear     (clear),
    .rd_data   (rd_data),
    .not_empty (not_empty),
    .level     (level),
    .rts       (rts)
  );

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic rd, input logic clr,
                     input int lvl, input logic ir);
    vec_t t;
    t.v = v; t.d = d; t.rd = rd; t.clr = clr;
    t.e_level = LW'(lvl); t.e_inread = ir;
    vecs.push_back(t);
  endtask

  function automatic logic exp_rts(input logic [LW-1:0] lvl);
`ifdef UART_RX_FIFO_RTS_EN
    return (int'(lvl) >= RTS_LEVEL);
`else
    return 1'b0;
`endif
  endfunction

  // Drive one vector, advance one edge, update the scoreboard, compare.
  task automatic step(input vec_t t, input int idx);
    int qs;
    in_valid = t.v; in_data = t.d; rd_req = t.rd; clear = t.clr;
    qs = sb.size();
    @(posedge clk); #1;
    if (t.clr) begin
      sb.delete();
    end else begin
      if (t.rd && qs > 0) void'(sb.pop_front());
      if (t.e_inread) sb.push_back(t.d);
    end
    chk("level",     idx, 32'(level),     32'(t.e_level));
    chk("in_read",   idx, 32'(in_read),   32'(t.e_inread));
    chk("not_empty", idx, 32'(not_empty), 32'(t.e_level != '0));
    chk("rd_data",   idx, 32'(rd_data),   32'((sb.size() > 0) ? sb[0] : 8'h00));
    chk("rts",       idx, 32'(rts),       32'(exp_rts(t.e_level)));
  endtask

  task automatic chk_reset_outputs(input int idx);
    chk("rst_level",     idx, 32'(level),     32'd0);
    chk("rst_in_read",   idx, 32'(in_read),   32'd0);
    chk("rst_not_empty", idx, 32'(not_empty), 32'd0);
    chk("rst_rd_data",   idx, 32'(rd_data),   32'd0);
    chk("rst_rts",       idx, 32'(rts),       32'd0);
  endtask

  initial begin
    vec_t t;
    rstn = 1'b0; in_valid = 1'b0; in_data = 8'h00; rd_req = 1'b0; clear = 1'b0;

    // Single byte held three cycles from the first post-reset cycle.
    add(1, 8'hA5, 0, 0, 0, 0);
    add(1, 8'hA5, 0, 0, 1, 1);
    add(1, 8'hA5, 0, 0, 1, 0);
    add(0, 8'h00, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 0, 0);
    // Fill to full, then a held fifth byte.
    for (int i = 1; i <= 4; i++) begin
      add(1, 8'(i), 0, 0, i, 1);
      add(0, 8'h00, 0, 0, i, 0);
    end
    add(1, 8'h05, 0, 0, 4, 0);
    add(1, 8'h05, 0, 0, 4, 0);
    // Full with a concurrent read: pop only, then the byte gets in.
    add(1, 8'h05, 1, 0, 3, 0);
    add(1, 8'h05, 0, 0, 4, 1);
    add(0, 8'h00, 0, 0, 4, 0);
    for (int i = 3; i >= 0; i--) add(0, 8'h00, 1, 0, i, 0);
    add(0, 8'h00, 1, 0, 0, 0);
    // Clear colliding with read and an arriving byte at level 3.
    add(1, 8'h11, 0, 0, 1, 1);
    add(0, 8'h00, 0, 0, 1, 0);
    add(1, 8'h22, 0, 0, 2, 1);
    add(0, 8'h00, 0, 0, 2, 0);
    add(1, 8'h33, 0, 0, 3, 1);
    add(0, 8'h00, 0, 0, 3, 0);
    add(1, 8'h44, 1, 1, 0, 0);
    add(0, 8'h00, 0, 0, 0, 0);
    // Pointer wrap with simultaneous push/pop pairs.
    add(1, 8'h50, 0, 0, 1, 1);
    add(0, 8'h00, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      add(1, 8'h60 + 8'(i), 1, 0, 1, 1);
      add(0, 8'h00, 0, 0, 1, 0);
    end
    add(0, 8'h00, 1, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs(0);
    rstn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    // Asynchronous reset while in_read is high and two bytes are stored.
    t.rd = 0; t.clr = 0;
    t.v = 1; t.d = 8'h71; t.e_level = LW'(1); t.e_inread = 1; step(t, 100);
    t.v = 0; t.d = 8'h00; t.e_level = LW'(1); t.e_inread = 0; step(t, 101);
    t.v = 1; t.d = 8'h72; t.e_level = LW'(2); t.e_inread = 1; step(t, 102);
    #2 rstn = 1'b0;
    #1 chk_reset_outputs(1);
    sb.delete();
    @(posedge clk); #1;
    chk_reset_outputs(2);
    rstn = 1'b1;
    // First eligible push is on the second edge after release.
    t.v = 1; t.d = 8'h77; t.e_level = LW'(0); t.e_inread = 0; step(t, 103);
    t.v = 1; t.d = 8'h77; t.e_level = LW'(1); t.e_inread = 1; step(t, 104);
    t.v = 0; t.d = 8'h00; t.e_level = LW'(1); t.e_inread = 0; step(t, 105);
    t.v = 0; t.rd = 1;    t.e_level = LW'(0); t.e_inread = 0; step(t, 106);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
